// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: address map constants and access decode shared by the responder.
package mem_io_responder_pkg;
    localparam logic [1:0]  IO_REGION     = 2'b11;
    localparam logic [15:0] IO_OFF_DATA   = 16'h0000;
    localparam logic [15:0] IO_OFF_CYCLES = 16'h0004;
    localparam logic [7:0]  ZERO_BYTE     = 8'h00;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_DATA,
        ACC_CYC,
        ACC_NONE
    } acc_e;

    function automatic acc_e decode_addr(input logic [17:0] a);
        if (a[17:16] != IO_REGION) return ACC_RAM;
        if (a[15:0] == IO_OFF_DATA) return ACC_DATA;
        if (a[15:2] == IO_OFF_CYCLES[15:2]) return ACC_CYC;
        return ACC_NONE;
    endfunction
endpackage

// File: rtl/mem_io_responder_tx_fifo.sv
// tx_fifo: byte FIFO feeding the UART, with registered almost-full and sticky overflow.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_almost_full,
    output logic       o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW + 1)'(DEPTH - 2);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          r_almost_full;
    logic          r_overflow;
    logic          w_pop;
    logic          w_push;
    logic [AW:0]   w_count_nxt;

    assign w_pop       = i_pop && r_count != '0;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push      = i_push && (r_count != FULL_CNT || w_pop);
    assign w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr          <= '0;
            r_rd          <= '0;
            r_count       <= '0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wr          <= r_wr + {{(AW-1){1'b0}}, w_push};
            r_rd          <= r_rd + {{(AW-1){1'b0}}, w_pop};
            r_count       <= w_count_nxt;
            r_almost_full <= w_count_nxt >= AF_CNT;
            if (i_push && !w_push) r_overflow <= 1'b1;
        end
    end

    assign o_data        = r_mem[r_rd];
    assign o_valid       = r_count != '0;
    assign o_almost_full = r_almost_full;
    assign o_overflow    = r_overflow;
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: single-cycle byte RAM plus memory-mapped UART, cycle counter and stop flag.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_done,
    output logic        tx_overflow
);
    logic [7:0]            r_ram [0:(1 << RAM_ADDR_W) - 1];
    logic [7:0]            r_mem_din;
    logic [31:0]           r_cycles;
    logic [31:0]           r_snap;
    logic                  r_done;
    acc_e                  w_acc;
    logic [RAM_ADDR_W-1:0] w_ram_addr;
    logic                  w_cyc_base;
    logic                  w_stop;
    logic                  w_push;
    logic [7:0]            w_rdata;
    logic                  w_unused;

    assign w_acc      = decode_addr(mem_a[17:0]);
    assign w_ram_addr = mem_a[RAM_ADDR_W-1:0];
    assign w_cyc_base = w_acc == ACC_CYC && mem_a[1:0] == 2'b00;
    assign w_stop     = mem_wr && w_cyc_base;
    assign w_push     = w_stop || (mem_wr && w_acc == ACC_DATA && mem_dout != ZERO_BYTE);
    assign rx_pop     = !rst_in && !mem_wr && w_acc == ACC_DATA && rx_valid;
    assign w_unused   = ^mem_a[31:18];

    // Offset 0x4 returns the live counter, which is the value being snapshotted at this edge.
    always_comb begin
        w_rdata = ZERO_BYTE;
        case (w_acc)
            ACC_RAM:  w_rdata = r_ram[w_ram_addr];
            ACC_DATA: w_rdata = rx_valid ? rx_data : ZERO_BYTE;
            ACC_CYC:  w_rdata = w_cyc_base ? r_cycles[7:0] : r_snap[{mem_a[1:0], 3'b000} +: 8];
            default:  w_rdata = ZERO_BYTE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (mem_wr && w_acc == ACC_RAM) r_ram[w_ram_addr] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_mem_din <= ZERO_BYTE;
            r_cycles  <= '0;
            r_snap    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
            if (!mem_wr) r_mem_din <= w_rdata;
            if (!mem_wr && w_cyc_base) r_snap <= r_cycles;
            if (w_stop) r_done <= 1'b1;
        end
    end

    tx_fifo #(.DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .i_push        (w_push),
        .i_data        (w_stop ? ZERO_BYTE : mem_dout),
        .i_pop         (tx_ready),
        .o_data        (tx_data),
        .o_valid       (tx_valid),
        .o_almost_full (io_buffer_full),
        .o_overflow    (tx_overflow)
    );

    assign mem_din      = r_mem_din;
    assign program_done = r_done;
endmodule
